// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command FIFO plus IDLE/EXEC/DONE sequencer feeding an external combinational ALU
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready    command handshake; o_cmd_ready = FIFO not full
//   i_cmd_oper, i_cmd_src        opcode (3'b100 = local clear), arg0 source (0: accumulator)
//   i_cmd_arg0, i_cmd_arg1       signed 10-bit operands
//   o_arg0, o_arg1, o_oper       registered operands/opcode presented to the ALU
//   i_result, i_flag             ALU result and flags {ovf,zero,pos,neg}
//   o_res_valid / i_res_ready    result handshake
//   o_res_data, o_res_flag       captured result and flags
//   o_acc, o_ovf_sticky, o_busy  accumulator, sticky overflow, activity indicator

module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [2:0] i_cmd_oper,
    input  logic       i_cmd_src,
    input  logic [9:0] i_cmd_arg0,
    input  logic [9:0] i_cmd_arg1,
    output logic [9:0] o_arg0,
    output logic [9:0] o_arg1,
    output logic [2:0] o_oper,
    input  logic [9:0] i_result,
    input  logic [3:0] i_flag,
    output logic       o_res_valid,
    input  logic       i_res_ready,
    output logic [9:0] o_res_data,
    output logic [3:0] o_res_flag,
    output logic [9:0] o_acc,
    output logic       o_ovf_sticky,
    output logic       o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] OP_CLR = 3'b100;

    typedef struct packed {
        logic [2:0] oper;
        logic       src;
        logic [9:0] arg0;
        logic [9:0] arg1;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    cmd_t            head;
    logic            head_clr;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = i_cmd_valid && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign head     = mem[rd_ptr];
    assign head_clr = (head.oper == OP_CLR);

    assign o_cmd_ready = !full;
    assign o_res_valid = (state_q == DONE);
    assign o_busy      = (state_q != IDLE) || !empty;

    // Storage has no reset; validity is tracked by count alone.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{oper: i_cmd_oper, src: i_cmd_src, arg0: i_cmd_arg0, arg1: i_cmd_arg1};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A clear is consumed in IDLE without leaving it, so back-to-back
    // clears and the next real command are handled on following cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop && !head_clr) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (i_res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_arg0       <= '0;
            o_arg1       <= '0;
            o_oper       <= '0;
            o_res_data   <= '0;
            o_res_flag   <= '0;
            o_acc        <= '0;
            o_ovf_sticky <= 1'b0;
        end else begin
            if (pop) begin
                if (head_clr) begin
                    o_acc        <= '0;
                    o_ovf_sticky <= 1'b0;
                end else begin
                    o_oper <= head.oper;
                    o_arg1 <= head.arg1;
                    o_arg0 <= head.src ? head.arg0 : o_acc;
                end
            end
            // The ALU is combinational on the registered operands, so its
            // output is settled by the end of the single EXEC cycle.
            if (state_q == EXEC) begin
                o_res_data <= i_result;
                o_res_flag <= i_flag;
                o_acc      <= i_result;
                if (i_flag[3]) o_ovf_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_cmd_valid  in  1  command present.
REQ-005 o_cmd_ready  out  1  command FIFO not full.
REQ-006 i_cmd_oper  in  3  ALU opcode; 3'b100 is local CLR.
REQ-007 i_cmd_src  in  1  0: arg0 = accumulator; 1: arg0 = i_cmd_arg0.
REQ-008 i_cmd_arg0  in  10  signed operand 0.
REQ-009 i_cmd_arg1  in  10  signed operand 1.
REQ-010 o_arg0, o_arg1  out  10 each  registered operands driven to the combinational ALU.
REQ-011 o_oper  out  3  registered opcode driven to the ALU.
REQ-012 i_result  in  10  ALU result; i_flag  in  4  ALU flags {ovf,zero,pos,neg}.
REQ-013 o_res_valid  out  1  result available; i_res_ready  in  1  consumer accepts.
REQ-014 o_res_data  out  10  captured result; o_res_flag  out  4  captured flags.
REQ-015 o_acc  out  10  accumulator; o_ovf_sticky  out  1  sticky overflow; o_busy  out  1  FSM not IDLE or FIFO non-empty.

Function
REQ-016 Push when i_cmd_valid && o_cmd_ready; entry = {oper, src, arg0, arg1}; o_cmd_ready = !full, independent of a same-cycle pop.
REQ-017 FSM states IDLE, EXEC, DONE; FIFO pops only in IDLE.
REQ-018 IDLE, FIFO non-empty, head oper != 3'b100: pop; load o_oper, o_arg1, and o_arg0 (o_acc if src=0, else arg0); -> EXEC.
REQ-019 IDLE, head oper == 3'b100: pop; o_acc <= 0; o_ovf_sticky <= 0; no ALU issue, no result; stay IDLE.
REQ-020 EXEC (exactly 1 cycle): at the cycle's end, capture i_result into o_res_data and o_acc, i_flag into o_res_flag; if i_flag[3], set o_ovf_sticky; -> DONE.
REQ-021 DONE: o_res_valid = 1; on i_res_ready, -> IDLE; o_res_data/o_res_flag held stable while o_res_valid && !i_res_ready.
REQ-022 o_arg0/o_arg1/o_oper change only on a pop in IDLE; held otherwise.
REQ-023 Latency: push at cycle N into empty FIFO with FSM IDLE -> o_res_valid high at N+3; max throughput one result per 3 cycles (i_res_ready held high).
REQ-024 Opcode 3'b101 is issued unmodified; whatever the ALU returns is captured.
REQ-025 Accumulator update is a plain 10-bit copy of i_result, no extension or saturation; o_ovf_sticky set only by the ALU flag.
REQ-026 Results emerge in command order; no command is dropped or duplicated.
REQ-027 FIFO pointers wrap modulo DEPTH; full when count == DEPTH, empty when count == 0.

Reset
REQ-028 i_rst asserted: immediately, FSM = IDLE, FIFO empty, and o_arg0, o_arg1, o_oper, o_res_data, o_res_flag, o_acc, o_ovf_sticky, o_res_valid, o_busy = 0; o_cmd_ready = 1.
REQ-029 Reset mid-operation (EXEC or DONE) discards the in-flight command and all queued commands; no result is emitted for them.
REQ-030 First push is accepted on the first rising edge after i_rst deasserts.

Verification (reference ALU model attached to o_arg*/o_oper)
REQ-031 After reset, push {000, src=1, 5, 3} at cycle N -> at N+3: o_res_valid=1, o_res_data=8, o_res_flag=4'b0010, o_acc=8.
REQ-032 Then push {001, src=0, x, 10} -> o_arg0=8, o_arg1=10; result 10'h3FE (-2), flag 4'b0001, o_acc=10'h3FE.
REQ-033 Push {000, src=1, 511, 1} -> o_res_data=10'h200, o_res_flag[3]=1, o_ovf_sticky=1; sticky remains 1 after a following {000, 1, 1, 1}; push {100} -> o_acc=0, o_ovf_sticky=0, no o_res_valid pulse.
REQ-034 Hold i_res_ready=0 and push 6 commands back-to-back -> 5 accepted (1 in DONE, 4 queued), o_cmd_ready=0 at the 6th; release i_res_ready -> 5 results in push order, o_busy falls after the last.
REQ-035 Assert i_rst during EXEC -> all outputs 0 in the same cycle, no result emitted; after release, o_cmd_ready=1 and a fresh {000, 1, 2, 2} returns 4 at N+3.
